// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the FP arithmetic unit.
// Holds the field widths, divider FSM states and field-extract helpers.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  // Quotient register width: integer bit, 23 fraction bits, one extra for the q[24]=0 case
  localparam int Q_W = MAN_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } div_state_e;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// Restoring mantissa divider: one quotient bit per step over Q_W steps.
// load seeds rem/div from the hidden-1 mantissas; last flags the final step.
module fp_div_mant_iter
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic [Q_W-1:0]   q,
  output logic             last
);

  logic [Q_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0] div_q, div_d;
  logic [Q_W-1:0] q_q, q_d;
  logic [4:0]     count_q, count_d;

  // rem stays below 2*div, so the shifted remainder always fits in Q_W bits
  always_comb begin
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    count_d = count_q;
    if (load) begin
      rem_d   = {2'b01, man_a};
      div_d   = {2'b01, man_b};
      q_d     = '0;
      count_d = '0;
    end else if (step) begin
      if (rem_q >= div_q) begin
        q_d   = {q_q[Q_W-2:0], 1'b1};
        rem_d = (rem_q - div_q) << 1;
      end else begin
        q_d   = {q_q[Q_W-2:0], 1'b0};
        rem_d = rem_q << 1;
      end
      count_d = count_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      count_q <= '0;
    end else begin
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      count_q <= count_d;
    end
  end

  assign q    = q_q;
  assign last = (count_q == 5'(Q_W - 1));

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential single-precision divider with start/busy/done handshake.
// Fixed 26-cycle latency; specials resolved in NORM alongside the normal result.
module fp_divider_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] ans,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  localparam logic signed [9:0] BIAS_E = 10'(BIAS);

  div_state_e state_q, state_d;
  logic accept, load, step, last;
  logic [Q_W-1:0] q;

  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [31:0]      ans_q, ans_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

  logic signed [9:0] e_raw, e_norm;
  logic [MAN_W-1:0]  mant;

  fp_div_mant_iter u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .man_a (fp_man(a)),
    .man_b (fp_man(b)),
    .q     (q),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DIVIDE;
      ST_DIVIDE: if (last)  state_d = ST_NORM;
      ST_NORM:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == ST_IDLE) && start;
    load   = accept;
    step   = (state_q == ST_DIVIDE);
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
  end

  // Exponent is kept 10-bit signed so out-of-range results are never wrapped
  always_comb begin
    e_raw  = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q}) + BIAS_E;
    e_norm = q[Q_W-1] ? e_raw : e_raw - 10'sd1;
    mant   = q[Q_W-1] ? q[Q_W-2:1] : q[Q_W-3:0];
  end

  always_comb begin
    sign_d  = sign_q;
    exp_a_d = exp_a_q;
    exp_b_d = exp_b_q;
    ans_d   = ans_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
    if (accept) begin
      sign_d  = fp_sign(a) ^ fp_sign(b);
      exp_a_d = fp_exp(a);
      exp_b_d = fp_exp(b);
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      dbz_d   = 1'b0;
    end else if (state_q == ST_NORM) begin
      if (exp_b_q == '0 && exp_a_q == '0) begin
        ans_d = {sign_q, 8'h00, 23'd0};
      end else if (exp_b_q == '0) begin
        ans_d = {sign_q, EXP_INF, 23'd0};
        dbz_d = 1'b1;
      end else if (exp_a_q == '0 || exp_b_q == EXP_INF) begin
        ans_d = {sign_q, 8'h00, 23'd0};
      end else if (exp_a_q == EXP_INF) begin
        ans_d = {sign_q, EXP_INF, 23'd0};
        ovf_d = 1'b1;
      end else if (e_norm >= 10'sd255) begin
        ans_d = {sign_q, EXP_INF, 23'd0};
        ovf_d = 1'b1;
      end else if (e_norm <= 10'sd0) begin
        ans_d = {sign_q, 8'h00, 23'd0};
        unf_d = 1'b1;
      end else begin
        ans_d = {sign_q, e_norm[7:0], mant};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      exp_a_q <= '0;
      exp_b_q <= '0;
      ans_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      sign_q  <= sign_d;
      exp_a_q <= exp_a_d;
      exp_b_q <= exp_b_d;
      ans_q   <= ans_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ans         = ans_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed bench for fp_divider_seq: hand-computed quotients, specials,
// handshake spacing and mid-operation reset.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, overflow, underflow, div_by_zero;
  logic [31:0] ans;

  int tests  = 0;
  int failed = 0;

  fp_divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .ans         (ans),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge, then scrambles the operands
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic runOp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_ans, input logic [2:0] exp_flags);
    int cyc;
    applyStimulus(av, bv);
    checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, 32'd26);
    checkOutput({tag, " ans"}, ans, exp_ans);
    checkOutput({tag, " flags"}, {29'd0, overflow, underflow, div_by_zero}, {29'd0, exp_flags});
    // A request during the DONE cycle must not be taken
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int first_at;
    int second_at;
    int cyc;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    checkOutput("reset outs", {ans[31:0]}, 32'd0);
    checkOutput("reset ctl", {27'd0, busy, done, overflow, underflow, div_by_zero}, 32'd0);
    rst = 1'b0;
    tick();

    // flags order: {overflow, underflow, div_by_zero}
    runOp("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);
    runOp("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000);
    runOp("-1.5/0.5", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 3'b000);
    runOp("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001);
    runOp("0/0",      32'h00000000, 32'h00000000, 32'h00000000, 3'b000);
    runOp("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 3'b010);

    // Held start: accepts at edges 1, 29, 57; done visible after edges 27 and 55
    ndone     = 0;
    first_at  = 0;
    second_at = 0;
    start = 1'b1;
    a     = 32'h40C00000;
    b     = 32'h40000000;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) first_at = k;
        else if (ndone == 2) second_at = k;
      end
    end
    start = 1'b0;
    checkOutput("hs done count", ndone, 32'd2);
    checkOutput("hs spacing", second_at - first_at, 32'd28);
    checkOutput("hs ans", ans, 32'h40400000);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("hs drain", {31'd0, done}, 32'd1);
    tick();

    runOp("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100);

    // Reset ten cycles into a divide must abort without a done pulse
    applyStimulus(32'h3F800000, 32'h40400000);
    for (int k = 0; k < 9; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort ans", ans, 32'd0);
    checkOutput("abort ctl", {27'd0, busy, done, overflow, underflow, div_by_zero}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) ndone++;
    end
    checkOutput("abort no done", ndone, 32'd0);

    // Reset outranks a simultaneous request
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'h40C00000;
    b     = 32'h40000000;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst beats start", {31'd0, busy}, 32'd0);

    runOp("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
